bin2bcd_iter: RTL

BIN2BCD_ITER -- requirements
Module: bin2bcd_iter

---
 rtl/bin2bcd_iter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/bin2bcd_iter.sv
// Iterative binary-to-BCD converter (shift-and-add-3, one bit per cycle).
//
// Parameters:
//   W      - binary operand width (4..32)
//   DIGITS - BCD digits produced; must satisfy 10^DIGITS >= 2^W
//   SIGNED - 1: bin_in is two's complement, the magnitude is converted
// Ports:
//   clk_in       - clock, rising edge
//   rst_n_in     - asynchronous active-low reset
//   bin_in       - binary operand, sampled when valid_in & ready_out
//   valid_in     - operand valid
//   ready_out    - converter idle, can accept an operand
//   bcd_out      - packed BCD result {most significant ... ones}
//   neg_out      - result is negative (SIGNED=1, nonzero magnitude)
//   ndigits_out  - number of significant digits (minimum 1)
//   valid_out    - result valid, held until ready_in
//   ready_in     - downstream accepts the result
module bin2bcd_iter #(
  parameter int unsigned W      = 18,
  parameter int unsigned DIGITS = 6,
  parameter int unsigned SIGNED = 0
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic [W-1:0]                 bin_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  output logic [4*DIGITS-1:0]          bcd_out,
  output logic                         neg_out,
  output logic [$clog2(DIGITS+1)-1:0]  ndigits_out,
  output logic                         valid_out,
  input  logic                         ready_in
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned NW = $clog2(DIGITS + 1);
  localparam int unsigned BW = 4 * DIGITS;

  // True when DIGITS decimal digits can represent every W-bit magnitude.
  function automatic bit digits_fit();
    longint unsigned pow;
    longint unsigned limit;
    pow   = 64'd1;
    limit = 64'd1 << W;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (pow < limit) pow = pow * 64'd10;
    end
    return pow >= limit;
  endfunction

  if (W < 4 || W > 32) begin : g_bad_width
    $error("bin2bcd_iter: W must be in 4..32");
  end
  if (!digits_fit()) begin : g_bad_digits
    $error("bin2bcd_iter: DIGITS too small for W");
  end

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    sr_q, sr_d;
  logic [BW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_q, sign_d;
  logic            neg_q, neg_d;
  logic [NW-1:0]   nd_q, nd_d;

  logic [W-1:0]    mag;
  logic [BW-1:0]   acc_adj;
  logic [BW-1:0]   acc_shift;
  logic [W-1:0]    sr_shift;
  logic [NW-1:0]   nd_calc;

  // Unsigned negation keeps -2^(W-1) as magnitude 2^(W-1).
  always_comb begin
    mag = bin_in;
    if (SIGNED != 0 && bin_in[W-1]) mag = (~bin_in) + W'(1);
  end

  // Add-3 correction on every digit >= 5, then one-bit left shift of {acc, sr}.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_shift = {acc_adj[BW-2:0], sr_q[W-1]};
    sr_shift  = {sr_q[W-2:0], 1'b0};
  end

  // Significant-digit count of the final accumulator value.
  always_comb begin
    nd_calc = NW'(1);
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc_shift[4*i +: 4] != 4'd0) nd_calc = NW'(i + 1);
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    neg_d   = neg_q;
    nd_d    = nd_q;
    unique case (state_q)
      StIdle: begin
        if (valid_in) begin
          sr_d    = mag;
          acc_d   = '0;
          sign_d  = (SIGNED != 0) && bin_in[W-1];
          cnt_d   = CW'(W);
          state_d = StShift;
        end
      end
      StShift: begin
        acc_d = acc_shift;
        sr_d  = sr_shift;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = StDone;
          nd_d    = nd_calc;
          neg_d   = sign_q && (acc_shift != '0);
        end
      end
      StDone: begin
        if (ready_in) begin
          state_d = StIdle;
          neg_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      neg_q   <= 1'b0;
      nd_q    <= NW'(1);
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      neg_q   <= neg_d;
      nd_q    <= nd_d;
    end
  end

  assign ready_out   = (state_q == StIdle);
  assign valid_out   = (state_q == StDone);
  assign bcd_out     = acc_q;
  assign neg_out     = neg_q;
  assign ndigits_out = nd_q;

endmodule
